run_det_sched: RTL and testbench
================================

Name: run_det_sched

Overview:
- Time-shares one consecutive-ones run detector between N_REQ serial requesters.
- Round-robin arbiter grants one requester per packet and streams its bits into the detector.
- Counts run matches over the packet (overlapping, Mealy style) and returns the count with a one-cycle done pulse.
- Sits between the serial front-ends and the status/interrupt logic.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- RUN_LEN, 3, consecutive 1s that constitute a match (1..15).
- CNT_W, 8, width of the per-packet match counter.
- TIMEOUT_CYC, 16, idle-beat limit; used only with RUNDET_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- req  in  N_REQ  per-requester packet request (level).
- s_valid  in  N_REQ  per-requester bit valid.
- s_data  in  N_REQ  per-requester serial bit.
- s_last  in  N_REQ  per-requester last-bit marker.
- s_ready  out  N_REQ  beat accepted; only the granted bit can be 1.
- grant  out  N_REQ  one-hot owner of detector; 0 when idle.
- busy  out  1  FSM not in IDLE.
- done  out  1  one-cycle packet-complete pulse.
- done_id  out  $clog2(N_REQ)  index of the completed requester; valid with done.
- match_cnt  out  CNT_W  matches in the completed packet; valid with done.
- abort  out  1  packet ended by timeout; valid with done.

Behaviour:
- Reset (async, rst=1): grant=0, s_ready=0, busy=0, done=0, done_id=0, match_cnt=0, abort=0. FSM goes to IDLE, rr pointer=0, run counter=0.
- FSM states: IDLE, STREAM, REPORT. All outputs are registered except s_ready.
- IDLE, when req!=0:
  - Pick the first set req bit, searching from rr pointer upward with wrap.
  - Register the one-hot grant and go to STREAM.
  - The grant is visible the cycle after req is seen.
- STREAM:
  - s_ready = grant (combinational).
  - A beat is the cycle where s_valid[g] & s_ready[g] are both 1.
  - Each beat feeds s_data[g] to the core.
  - Core hit increments the internal count, saturating at 2^CNT_W-1.
  - A beat with s_last[g]=1 (its hit counted) moves the FSM to REPORT.
  - Cycles without a beat are stalls: the run counter holds, so a stall does not break a run.
- REPORT (exactly one cycle):
  - done=1, done_id=g, match_cnt=final count.
  - The core is cleared and the internal count reset.
  - rr pointer = g+1 (mod N_REQ).
  - grant=0, then return to IDLE.
  - Minimum inter-packet gap is 2 cycles (REPORT, IDLE).
- Match rule (core):
  - run counter cnt counts consecutive accepted 1s, saturating at RUN_LEN-1. A 0 beat clears it.
  - hit = beat & bit & (cnt==RUN_LEN-1).
  - Hence a run of K ones gives max(0, K-RUN_LEN+1) hits. With RUN_LEN=1, every 1 is a hit.
- Boundary cases:
  - req dropping during STREAM is ignored; grant is held until last.
  - s_valid/s_last on non-granted lanes are ignored.
  - A single-beat packet (valid & last in the first STREAM cycle) is legal.
  - Saturated count stays at max.
  - rst mid-packet aborts silently: no done pulse.
- done, done_id, match_cnt and abort hold their values outside REPORT except done, which is 0.

Optional Feature:
- Macro RUNDET_TIMEOUT_EN.
- Defined:
  - An idle counter increments on each STREAM cycle with no beat and clears on any beat.
  - Reaching TIMEOUT_CYC forces REPORT with abort=1 and match_cnt = count so far.
- Undefined: no counter; abort is tied 0; a stalled requester holds the grant indefinitely.

Decomposition:
- Shared package run_det_pkg holds:
  - the state enum (IDLE/STREAM/REPORT);
  - the helper function for id width ($clog2 wrapper);
  - the default constants RUN_LEN_DEF=3, CNT_W_DEF=8.
- One sub-module, run_det_core:
  - ports: clk, rst, clr, en, bit, hit;
  - parameter RUN_LEN;
  - holds the saturating run counter and the Mealy hit.
- Arbiter and FSM live in run_det_sched.

Test Plan:
- req=0001, lane0 streams 1,1,1,1,0,1,1 (last on the 7th beat) -> grant=0001 for the packet, done with done_id=0, match_cnt=2.
- req=1111 held for four packets of bits 1,1,1 each -> grant order 0001, 0010, 0100, 1000, each done with match_cnt=1; rr pointer wraps to 0.
- Lane2 sends 1,1, then s_valid=0 for 5 cycles, then 1 with last -> match_cnt=1 (stall does not break the run); s_ready[2] stays high throughout.
- CNT_W=2, packet of 10 consecutive 1s -> match_cnt=3 (saturated).
- rst asserted mid-packet -> next cycle grant=0, busy=0, no done. A following packet 1,1,1 -> match_cnt=1 (core cleared).
- With RUNDET_TIMEOUT_EN, TIMEOUT_CYC=4, lane1 sends 1,1,1 then goes silent -> after 4 idle cycles done=1, abort=1, match_cnt=1, done_id=1.

Source files
------------

// File: rtl/run_det_pkg.sv
// Shared types and defaults for the time-shared run detector.
package run_det_pkg;

    localparam int RUN_LEN_DEF = 3;
    localparam int CNT_W_DEF   = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        REPORT = 2'd2
    } state_e;

    // Requester-index width; never narrower than one bit.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/run_det_core.sv
// Consecutive-ones detector: saturating run counter with a Mealy hit output.
module run_det_core
    import run_det_pkg::*;
#(
    parameter int RUN_LEN = RUN_LEN_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic bit_i,
    output logic hit
);

    localparam int RW = (RUN_LEN > 1) ? $clog2(RUN_LEN) : 1;
    localparam logic [RW-1:0] RUN_MAX = RW'(RUN_LEN - 1);

    logic [RW-1:0] cnt_q;

    assign hit = en & bit_i & (cnt_q == RUN_MAX);

    // Count holds on cycles without a beat so stalls never break a run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            if (!bit_i)
                cnt_q <= '0;
            else if (cnt_q != RUN_MAX)
                cnt_q <= cnt_q + RW'(1);
        end
    end

endmodule

// File: rtl/run_det_sched.sv
// Round-robin scheduler sharing one run detector among N_REQ serial requesters.
// Build option RUNDET_TIMEOUT_EN adds an idle-beat timeout that aborts a stalled packet.
module run_det_sched
    import run_det_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int RUN_LEN     = RUN_LEN_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0]       s_valid,
    input  logic [N_REQ-1:0]       s_data,
    input  logic [N_REQ-1:0]       s_last,
    output logic [N_REQ-1:0]       s_ready,
    output logic [N_REQ-1:0]       grant,
    output logic                   busy,
    output logic                   done,
    output logic [id_w(N_REQ)-1:0] done_id,
    output logic [CNT_W-1:0]       match_cnt,
    output logic                   abort
);

    localparam int ID_W = id_w(N_REQ);

    if (N_REQ < 2 || N_REQ > 8 || RUN_LEN < 1 || RUN_LEN > 15 || CNT_W < 1 || TIMEOUT_CYC < 1)
    begin : g_param_chk
        $error("run_det_sched: parameter out of range");
    end

    state_e           state_q;
    logic [ID_W-1:0]  rr_q, rr_d, gidx_q;
    logic [N_REQ-1:0] grant_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, done_q, abort_q;
    logic [ID_W-1:0]  done_id_q;
    logic [CNT_W-1:0] match_cnt_q;

    logic             beat, cur_bit, cur_last, hit, core_clr, tmo;
    logic             pick_vld, hi_vld;
    logic [ID_W-1:0]  pick_idx, hi_idx, lo_idx;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        if (inc && (v != '1))
            return v + CNT_W'(1);
        return v;
    endfunction

    assign s_ready  = (state_q == STREAM) ? grant_q : '0;
    assign beat     = |(s_valid & s_ready);
    assign cur_bit  = s_data[gidx_q];
    assign cur_last = s_last[gidx_q];
    assign core_clr = (state_q == REPORT);
    assign cnt_d    = sat_inc(cnt_q, hit);
    assign rr_d     = (int'(gidx_q) == N_REQ - 1) ? '0 : gidx_q + ID_W'(1);

    run_det_core #(
        .RUN_LEN (RUN_LEN)
    ) u_core (
        .clk   (clk),
        .rst   (rst),
        .clr   (core_clr),
        .en    (beat),
        .bit_i (cur_bit),
        .hit   (hit)
    );

    // Lowest set request at or above the pointer wins, else the lowest overall (wrap).
    always_comb begin
        pick_vld = 1'b0;
        hi_vld   = 1'b0;
        lo_idx   = '0;
        hi_idx   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                pick_vld = 1'b1;
                lo_idx   = ID_W'(i);
                if (i >= int'(rr_q)) begin
                    hi_vld = 1'b1;
                    hi_idx = ID_W'(i);
                end
            end
        end
        pick_idx = hi_vld ? hi_idx : lo_idx;
    end

`ifdef RUNDET_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] idle_q;

    assign tmo = (state_q == STREAM) && !beat && (idle_q == TO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            idle_q <= '0;
        else if (state_q != STREAM || beat)
            idle_q <= '0;
        else
            idle_q <= idle_q + TO_W'(1);
    end
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_q        <= '0;
            gidx_q      <= '0;
            grant_q     <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            done_id_q   <= '0;
            match_cnt_q <= '0;
            abort_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_vld) begin
                        grant_q <= N_REQ'(1) << pick_idx;
                        gidx_q  <= pick_idx;
                        busy_q  <= 1'b1;
                        state_q <= STREAM;
                    end
                end
                STREAM: begin
                    if (beat)
                        cnt_q <= cnt_d;
                    if ((beat && cur_last) || tmo) begin
                        grant_q     <= '0;
                        done_q      <= 1'b1;
                        done_id_q   <= gidx_q;
                        match_cnt_q <= cnt_d;
                        abort_q     <= tmo;
                        state_q     <= REPORT;
                    end
                end
                REPORT: begin
                    cnt_q   <= '0;
                    rr_q    <= rr_d;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant     = grant_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign done_id   = done_id_q;
    assign match_cnt = match_cnt_q;
    assign abort     = abort_q;

endmodule

// File: tb/tb_run_det_sched.sv
// Randomised self-checking bench for run_det_sched against a behavioural model.
module tb_run_det_sched;

    localparam int N  = 4;
    localparam int RL = 3;
    localparam int TO = 4;
`ifdef RUNDET_TIMEOUT_EN
    localparam int STALL = 3;
`else
    localparam int STALL = 5;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req, s_valid, s_data, s_last;
    logic [N-1:0] s_ready, grant, s_ready_s, grant_s;
    logic         busy, done, abort, busy_s, done_s, abort_s;
    logic [1:0]   done_id, done_id_s;
    logic [7:0]   match_cnt;
    logic [1:0]   match_cnt_s;

    int n_checks = 0;
    int n_fail   = 0;
    int mrr      = 0;

    always #5 clk = ~clk;

    run_det_sched #(.N_REQ(N), .RUN_LEN(RL), .CNT_W(8), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
        .s_ready(s_ready), .grant(grant), .busy(busy), .done(done), .done_id(done_id),
        .match_cnt(match_cnt), .abort(abort)
    );

    run_det_sched #(.N_REQ(N), .RUN_LEN(RL), .CNT_W(2), .TIMEOUT_CYC(TO)) dut_s (
        .clk(clk), .rst(rst), .req(req), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
        .s_ready(s_ready_s), .grant(grant_s), .busy(busy_s), .done(done_s), .done_id(done_id_s),
        .match_cnt(match_cnt_s), .abort(abort_s)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_hits(input logic [31:0] b, input int n);
        int run = 0;
        int h = 0;
        for (int k = 0; k < n; k++) begin
            if (b[k]) run++;
            else run = 0;
            if (b[k] && run >= RL) h++;
        end
        return h;
    endfunction

    function automatic int model_pick(input logic [N-1:0] r, input int rr);
        for (int i = 0; i < N; i++) begin
            if (r[(rr + i) % N]) return (rr + i) % N;
        end
        return -1;
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // Waits for a grant, streams bits on the granted lane with stalls and
    // noise on other lanes, then captures the report cycle.
    task automatic run_packet(input logic [31:0] bits, input int nbits, input int stall_max,
                              input logic [31:0] stall_at, input int stall_len, input bit noise_req,
                              output int lane, output bit rdy_ok, output bit got_done,
                              output logic [1:0] id, output logic [7:0] cnt, output logic [1:0] cnt_s,
                              output logic ab, output bit done_clr, output logic [N-1:0] rep_gnt);
        logic [N-1:0] exp_rdy;
        int st;
        lane = -1; rdy_ok = 1'b1; got_done = 1'b0; id = '0; cnt = '0; cnt_s = '0;
        ab = 1'b0; done_clr = 1'b0; rep_gnt = '1;
        for (int c = 0; c < 8 && grant == '0; c++) tick();
        for (int i = 0; i < N; i++) if (grant[i]) lane = i;
        if (lane < 0) return;
        exp_rdy = '0;
        exp_rdy[lane] = 1'b1;
        for (int k = 0; k < nbits; k++) begin
            st = stall_at[k] ? stall_len : ((stall_max > 0) ? int'($urandom_range(stall_max, 0)) : 0);
            for (int s = 0; s <= st; s++) begin
                s_valid = N'($urandom);
                s_data  = N'($urandom);
                s_last  = N'($urandom);
                if (s < st) begin
                    s_valid[lane] = 1'b0;
                end else begin
                    s_valid[lane] = 1'b1;
                    s_data[lane]  = bits[k];
                    s_last[lane]  = (k == nbits - 1);
                end
                if (noise_req) req = N'($urandom);
                if (s_ready !== exp_rdy || s_ready_s !== exp_rdy) rdy_ok = 1'b0;
                tick();
            end
        end
        s_valid = '0; s_last = '0; s_data = '0;
        if (noise_req) req = '0;
        got_done = done; id = done_id; cnt = match_cnt; cnt_s = match_cnt_s; ab = abort; rep_gnt = grant;
        tick();
        done_clr = (done === 1'b0) && (done_s === 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0; s_valid = '0; s_data = '0; s_last = '0;
        tick();
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        mrr = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = '0; s_valid = '0; s_data = '0; s_last = '0;
        tick();
        n_checks++; if (grant !== '0)     begin n_fail++; $display("FAIL reset_grant got=%b want=0", grant); end
        n_checks++; if (s_ready !== '0)   begin n_fail++; $display("FAIL reset_ready got=%b want=0", s_ready); end
        n_checks++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
        n_checks++; if (done !== 1'b0)    begin n_fail++; $display("FAIL reset_done got=%b want=0", done); end
        n_checks++; if (done_id !== '0)   begin n_fail++; $display("FAIL reset_id got=%0d want=0", done_id); end
        n_checks++; if (match_cnt !== '0) begin n_fail++; $display("FAIL reset_cnt got=%0d want=0", match_cnt); end
        n_checks++; if (abort !== 1'b0)   begin n_fail++; $display("FAIL reset_abort got=%b want=0", abort); end
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        mrr = 0;
    endtask

    task automatic test_basic();
        int lane, exp_lane, exp;
        bit rdy_ok, got_done, done_clr;
        logic [1:0] id, cnt_s;
        logic [7:0] cnt;
        logic ab;
        logic [N-1:0] rep_gnt;
        req = 4'b0001;
        exp_lane = model_pick(req, mrr);
        exp = model_hits(32'h6F, 7);
        run_packet(32'h6F, 7, 0, 32'h0, 0, 1'b0, lane, rdy_ok, got_done, id, cnt, cnt_s, ab, done_clr, rep_gnt);
        req = '0;
        n_checks++; if (lane !== exp_lane)       begin n_fail++; $display("FAIL basic_lane got=%0d want=%0d", lane, exp_lane); end
        n_checks++; if (got_done !== 1'b1)       begin n_fail++; $display("FAIL basic_done got=%b want=1", got_done); end
        n_checks++; if (id !== 2'(exp_lane))     begin n_fail++; $display("FAIL basic_id got=%0d want=%0d", id, exp_lane); end
        n_checks++; if (cnt !== 8'(exp))         begin n_fail++; $display("FAIL basic_cnt got=%0d want=%0d", cnt, exp); end
        n_checks++; if (ab !== 1'b0)             begin n_fail++; $display("FAIL basic_abort got=%b want=0", ab); end
        n_checks++; if (!rdy_ok)                 begin n_fail++; $display("FAIL basic_ready got=bad want=onehot"); end
        n_checks++; if (!done_clr)               begin n_fail++; $display("FAIL basic_done_pulse got=long want=1cycle"); end
        n_checks++; if (rep_gnt !== '0)          begin n_fail++; $display("FAIL basic_report_grant got=%b want=0", rep_gnt); end
        mrr = (exp_lane + 1) % N;
    endtask

    task automatic test_round_robin();
        int lane, exp_lane;
        bit rdy_ok, got_done, done_clr;
        logic [1:0] id, cnt_s;
        logic [7:0] cnt;
        logic ab;
        logic [N-1:0] rep_gnt;
        do_reset();
        req = 4'b1111;
        for (int p = 0; p < 5; p++) begin
            exp_lane = model_pick(req, mrr);
            run_packet(32'h7, 3, 0, 32'h0, 0, 1'b0, lane, rdy_ok, got_done, id, cnt, cnt_s, ab, done_clr, rep_gnt);
            n_checks++; if (lane !== exp_lane || exp_lane !== p % N)
                begin n_fail++; $display("FAIL rr_lane[%0d] got=%0d want=%0d", p, lane, p % N); end
            n_checks++; if (got_done !== 1'b1 || id !== 2'(exp_lane) || cnt !== 8'd1)
                begin n_fail++; $display("FAIL rr_report[%0d] got done=%b id=%0d cnt=%0d want done=1 id=%0d cnt=1", p, got_done, id, cnt, exp_lane); end
            mrr = (exp_lane + 1) % N;
        end
        req = '0;
    endtask

    task automatic test_stall();
        int lane, exp_lane, exp;
        bit rdy_ok, got_done, done_clr;
        logic [1:0] id, cnt_s;
        logic [7:0] cnt;
        logic ab;
        logic [N-1:0] rep_gnt;
        req = 4'b0100;
        exp_lane = model_pick(req, mrr);
        exp = model_hits(32'h7, 3);
        run_packet(32'h7, 3, 0, 32'h4, STALL, 1'b0, lane, rdy_ok, got_done, id, cnt, cnt_s, ab, done_clr, rep_gnt);
        req = '0;
        n_checks++; if (lane !== exp_lane) begin n_fail++; $display("FAIL stall_lane got=%0d want=%0d", lane, exp_lane); end
        n_checks++; if (!rdy_ok)           begin n_fail++; $display("FAIL stall_ready got=dropped want=held"); end
        n_checks++; if (got_done !== 1'b1 || cnt !== 8'(exp) || ab !== 1'b0)
            begin n_fail++; $display("FAIL stall_cnt got done=%b cnt=%0d abort=%b want done=1 cnt=%0d abort=0", got_done, cnt, ab, exp); end
        mrr = (exp_lane + 1) % N;
    endtask

    task automatic test_saturation();
        int lane, exp_lane, h;
        bit rdy_ok, got_done, done_clr;
        logic [1:0] id, cnt_s;
        logic [7:0] cnt;
        logic ab;
        logic [N-1:0] rep_gnt;
        req = 4'b1000;
        exp_lane = model_pick(req, mrr);
        h = model_hits(32'h3FF, 10);
        run_packet(32'h3FF, 10, 0, 32'h0, 0, 1'b0, lane, rdy_ok, got_done, id, cnt, cnt_s, ab, done_clr, rep_gnt);
        req = '0;
        n_checks++; if (cnt !== 8'(sat(h, 255))) begin n_fail++; $display("FAIL sat_wide got=%0d want=%0d", cnt, sat(h, 255)); end
        n_checks++; if (cnt_s !== 2'(sat(h, 3))) begin n_fail++; $display("FAIL sat_narrow got=%0d want=%0d", cnt_s, sat(h, 3)); end
        mrr = (exp_lane + 1) % N;
    endtask

    task automatic test_rst_mid();
        int lane, exp_lane, seen_done;
        bit rdy_ok, got_done, done_clr;
        logic [1:0] id, cnt_s;
        logic [7:0] cnt;
        logic ab;
        logic [N-1:0] rep_gnt;
        req = 4'b0001;
        for (int c = 0; c < 8 && grant == '0; c++) tick();
        req = '0;
        for (int k = 0; k < 2; k++) begin
            s_valid = 4'b0001; s_data = 4'b0001; s_last = '0;
            tick();
        end
        s_valid = '0; s_data = '0;
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++; if (grant !== '0 || busy !== 1'b0)
            begin n_fail++; $display("FAIL rstmid_idle got grant=%b busy=%b want grant=0 busy=0", grant, busy); end
        seen_done = 0;
        if (done !== 1'b0) seen_done++;
        #2 rst = 1'b0;
        mrr = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (done !== 1'b0) seen_done++;
        end
        n_checks++; if (seen_done != 0) begin n_fail++; $display("FAIL rstmid_nodone got=%0d pulses want=0", seen_done); end
        req = 4'b0010;
        exp_lane = model_pick(req, mrr);
        run_packet(32'h7, 3, 0, 32'h0, 0, 1'b0, lane, rdy_ok, got_done, id, cnt, cnt_s, ab, done_clr, rep_gnt);
        req = '0;
        n_checks++; if (lane !== exp_lane || cnt !== 8'd1 || got_done !== 1'b1)
            begin n_fail++; $display("FAIL rstmid_after got lane=%0d cnt=%0d done=%b want lane=%0d cnt=1 done=1", lane, cnt, got_done, exp_lane); end
        mrr = (exp_lane + 1) % N;
    endtask

    task automatic test_random();
        int lane, exp_lane, nb, h;
        bit rdy_ok, got_done, done_clr;
        logic [1:0] id, cnt_s;
        logic [7:0] cnt;
        logic ab;
        logic [N-1:0] rep_gnt;
        logic [31:0] bits;
        for (int p = 0; p < 24; p++) begin
            req  = N'($urandom_range(15, 1));
            nb   = $urandom_range(24, 1);
            bits = $urandom;
            if (p % 3 == 0) bits = bits | 32'h00FF_F0F0;
            exp_lane = model_pick(req, mrr);
            h = model_hits(bits, nb);
            run_packet(bits, nb, 2, 32'h0, 0, 1'b1, lane, rdy_ok, got_done, id, cnt, cnt_s, ab, done_clr, rep_gnt);
            n_checks++; if (lane !== exp_lane)
                begin n_fail++; $display("FAIL rand_lane[%0d] got=%0d want=%0d", p, lane, exp_lane); end
            n_checks++; if (got_done !== 1'b1 || id !== 2'(exp_lane) || ab !== 1'b0 || !done_clr || !rdy_ok)
                begin n_fail++; $display("FAIL rand_ctrl[%0d] got done=%b id=%0d abort=%b pulse=%b ready=%b want 1 %0d 0 1 1", p, got_done, id, ab, done_clr, rdy_ok, exp_lane); end
            n_checks++; if (cnt !== 8'(sat(h, 255)) || cnt_s !== 2'(sat(h, 3)))
                begin n_fail++; $display("FAIL rand_cnt[%0d] got=%0d/%0d want=%0d/%0d", p, cnt, cnt_s, sat(h, 255), sat(h, 3)); end
            mrr = (exp_lane + 1) % N;
        end
        req = '0;
    endtask

`ifdef RUNDET_TIMEOUT_EN
    task automatic test_timeout();
        int k;
        req = 4'b0010;
        for (int c = 0; c < 8 && grant == '0; c++) tick();
        req = '0;
        for (int b = 0; b < 3; b++) begin
            s_valid = 4'b0010; s_data = 4'b0010; s_last = '0;
            tick();
        end
        s_valid = '0; s_data = '0;
        k = 0;
        while (done !== 1'b1 && k < 10) begin
            tick();
            k++;
        end
        n_checks++; if (k != TO) begin n_fail++; $display("FAIL tmo_delay got=%0d want=%0d", k, TO); end
        n_checks++; if (abort !== 1'b1 || match_cnt !== 8'd1 || done_id !== 2'd1)
            begin n_fail++; $display("FAIL tmo_report got abort=%b cnt=%0d id=%0d want 1 1 1", abort, match_cnt, done_id); end
        tick();
        n_checks++; if (done !== 1'b0 || busy !== 1'b0)
            begin n_fail++; $display("FAIL tmo_idle got done=%b busy=%b want 0 0", done, busy); end
        mrr = 2;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_stall();
        test_saturation();
        test_rst_mid();
        test_random();
`ifdef RUNDET_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
